// File: rtl/dec_scan_ctrl_pkg.sv
// Shared types and helpers for the dec2_4 scan sequencer.
package dec_scan_ctrl_pkg;

  // Scan FSM state encodings.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DWELL = 2'd1,
    S_BLANK = 2'd2
  } state_t;

  localparam int NCH = 4;

  // Bits needed for a counter that runs 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Index of the lowest set bit of m (0 when m is empty).
  function automatic logic [1:0] first_set(input logic [3:0] m);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Next enabled channel strictly above cur, wrapping 3->0. The mask is
  // rotated so that bit 0 is the channel after cur; the lowest set bit of the
  // rotated mask is then the distance to the next channel minus one. A
  // single-bit mask comes back to cur itself.
  function automatic logic [1:0] next_ch(input logic [3:0] m, input logic [1:0] cur);
    logic [3:0] rot;
    for (int j = 0; j < NCH; j++) begin
      rot[j] = m[cur + 2'd1 + 2'(j)];
    end
    return cur + 2'd1 + first_set(rot);
  endfunction

endpackage

// File: rtl/dec_scan_ctrl_tick_gen.sv
// Scan-tick prescaler: one-cycle tick every DIV clocks, realigned by clr.
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  import dec_scan_ctrl_pkg::*;

  localparam int PW = cnt_width(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] cnt;

  // Prescale counter: held at zero while cleared, wraps after DIV cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // The DIV-th cycle after clear carries the tick.
  assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/dec_scan_ctrl.sv
// Round-robin scan sequencer driving the select code and enable of a dec2_4.
//
// Control pulses: start and stop are single-cycle pulses sampled on the
// rising clock edge. start (with mask and one_shot) is accepted only in
// IDLE with a non-zero mask; stop wins over start and over pass completion
// in the same cycle. There is no back-pressure.
module dec_scan_ctrl #(
  parameter int DIV   = 4,
  parameter int DWELL = 3,
  parameter int BLANK = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       one_shot,
  input  logic [3:0] mask,
  output logic [1:0] b,
  output logic       en,
  output logic       busy,
  output logic       done
);
  import dec_scan_ctrl_pkg::*;

  localparam int TMAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int TW   = cnt_width(TMAX);
  localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'((BLANK > 0) ? BLANK - 1 : 0);

  state_t        state, state_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic [3:0]    mask_q, mask_nxt;
  logic          os_q, os_nxt;
  logic [1:0]    b_nxt;
  logic          en_nxt, busy_nxt, done_nxt;
  logic          tick;
  logic [1:0]    adv_ch;
  logic          adv_wrap;
  logic          advance;

  // Prescaler runs only outside IDLE, so ticks line up with state entry.
  tick_gen #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == S_IDLE),
    .tick  (tick)
  );

  // State, tick counter, sampled controls and registered decoder outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      tcnt   <= '0;
      mask_q <= '0;
      os_q   <= 1'b0;
      b      <= 2'd0;
      en     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      tcnt   <= tcnt_nxt;
      mask_q <= mask_nxt;
      os_q   <= os_nxt;
      b      <= b_nxt;
      en     <= en_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
    end
  end

  // Next-state and next-output decode; advance covers the channel hand-off
  // from either the end of BLANK or, with no gap, the end of DWELL.
  always_comb begin
    state_nxt = state;
    tcnt_nxt  = tcnt;
    mask_nxt  = mask_q;
    os_nxt    = os_q;
    b_nxt     = b;
    en_nxt    = en;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    advance   = 1'b0;
    adv_ch    = next_ch(mask_q, b);
    adv_wrap  = (adv_ch <= b);

    case (state)
      S_IDLE: begin
        if (start && (mask != 4'd0)) begin
          state_nxt = S_DWELL;
          tcnt_nxt  = '0;
          mask_nxt  = mask;
          os_nxt    = one_shot;
          b_nxt     = first_set(mask);
          en_nxt    = 1'b1;
          busy_nxt  = 1'b1;
        end
      end
      S_DWELL: begin
        if (tick) begin
          if (tcnt == DWELL_LAST) begin
            tcnt_nxt = '0;
            if (BLANK == 0) begin
              advance = 1'b1;
            end else begin
              state_nxt = S_BLANK;
              en_nxt    = 1'b0;
            end
          end else begin
            tcnt_nxt = tcnt + 1'b1;
          end
        end
      end
      S_BLANK: begin
        if (tick) begin
          if (tcnt == BLANK_LAST) begin
            tcnt_nxt = '0;
            advance  = 1'b1;
          end else begin
            tcnt_nxt = tcnt + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
        b_nxt     = 2'd0;
        en_nxt    = 1'b0;
        busy_nxt  = 1'b0;
      end
    endcase

    if (advance) begin
      if (os_q && adv_wrap) begin
        state_nxt = S_IDLE;
        b_nxt     = 2'd0;
        en_nxt    = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b1;
      end else begin
        state_nxt = S_DWELL;
        b_nxt     = adv_ch;
        en_nxt    = 1'b1;
      end
    end

    if (stop) begin
      state_nxt = S_IDLE;
      tcnt_nxt  = '0;
      b_nxt     = 2'd0;
      en_nxt    = 1'b0;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b0;
    end
  end

endmodule

// File: tb/tb_dec_scan_ctrl.sv
// Bench for dec_scan_ctrl: three parameterisations share one stimulus
// stream and are checked each cycle against a timeline model.
module tb_dec_scan_ctrl;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       one_shot = 1'b0;
  logic [3:0] mask = 4'd0;

  logic [1:0] b0, b1, b2;
  logic       en0, en1, en2, busy0, busy1, busy2, done0, done1, done2;

  always #5 clk = ~clk;

  dec_scan_ctrl #(.DIV(1), .DWELL(2), .BLANK(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .one_shot(one_shot),
    .mask(mask), .b(b0), .en(en0), .busy(busy0), .done(done0));
  dec_scan_ctrl #(.DIV(4), .DWELL(3), .BLANK(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .one_shot(one_shot),
    .mask(mask), .b(b1), .en(en1), .busy(busy1), .done(done1));
  dec_scan_ctrl #(.DIV(2), .DWELL(2), .BLANK(0)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .one_shot(one_shot),
    .mask(mask), .b(b2), .en(en2), .busy(busy2), .done(done2));

  int vectors = 0;
  int miscompares = 0;

  function automatic int p_div(input int k);
    case (k) 0: return 1; 1: return 4; default: return 2; endcase
  endfunction
  function automatic int p_dwell(input int k);
    case (k) 0: return 2; 1: return 3; default: return 2; endcase
  endfunction
  function automatic int p_blank(input int k);
    case (k) 0: return 1; 1: return 1; default: return 0; endcase
  endfunction

  // {done, busy, en, b} of instance k
  function automatic logic [4:0] dut_out(input int k);
    case (k)
      0:       return {done0, busy0, en0, b0};
      1:       return {done1, busy1, en1, b1};
      default: return {done2, busy2, en2, b2};
    endcase
  endfunction

  // ---------------- behavioural model ----------------
  // A scan is a timeline: t counts cycles since the start edge. Each channel
  // of the pass list occupies (DWELL+BLANK)*DIV cycles, en high for the
  // first DWELL*DIV of them. One-shot: cycle n*period is the done cycle.
  bit act_m[3];
  bit os_m[3];
  int t_m[3];
  int n_m[3];
  int lst_m[3][4];
  logic [14:0] exp_q[$];

  function automatic int period(input int k);
    return (p_dwell(k) + p_blank(k)) * p_div(k);
  endfunction

  function automatic bit model_busy(input int k);
    return act_m[k] && (!os_m[k] || (t_m[k] < n_m[k] * period(k)));
  endfunction

  function automatic logic [4:0] model_out(input int k);
    int idx, ph;
    if (!act_m[k]) return 5'b00000;
    if (os_m[k] && (t_m[k] >= n_m[k] * period(k))) return 5'b10000;
    idx = (t_m[k] / period(k)) % n_m[k];
    ph  = t_m[k] % period(k);
    return {1'b0, 1'b1, (ph < p_dwell(k) * p_div(k)), 2'(lst_m[k][idx])};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        act_m[k] = 1'b0;
      end else if (stop) begin
        act_m[k] = 1'b0;
      end else if (!model_busy(k) && start && (mask != 4'd0)) begin
        act_m[k] = 1'b1;
        os_m[k]  = one_shot;
        t_m[k]   = 0;
        n_m[k]   = 0;
        for (int c = 0; c < 4; c++) begin
          if (mask[c]) begin
            lst_m[k][n_m[k]] = c;
            n_m[k]++;
          end
        end
      end else if (act_m[k]) begin
        t_m[k]++;
        if (os_m[k] && (t_m[k] > n_m[k] * period(k))) act_m[k] = 1'b0;
      end
    end
    exp_q.push_back({model_out(2), model_out(1), model_out(0)});
  end

  // ---------------- scoreboard ----------------
  bit chk_en = 1'b0;

  always @(negedge clk) begin
    logic [14:0] exp_all;
    logic [4:0]  got, want;
    if (chk_en && (exp_q.size() > 0)) begin
      exp_all = exp_q[$];
      exp_q.delete();
      for (int k = 0; k < 3; k++) begin
        got  = dut_out(k);
        want = exp_all[k*5 +: 5];
        vectors++;
        if (got !== want) begin
          miscompares++;
          $display("FAIL model_u%0d @%0t done/busy/en/b got %b required %b", k, $time, got, want);
        end
      end
    end
  end

  task automatic check5(input string nm, input logic [4:0] got, input logic [4:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s done/busy/en/b got %b required %b", nm, got, want);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s got %0d required %0d", nm, got, want);
    end
  endtask

  // ---------------- driver tasks ----------------
  logic [4:0] cap[3][64];

  task automatic pulse_start(input logic [3:0] m, input bit os, input bit with_stop);
    @(posedge clk); #1;
    start = 1'b1; stop = with_stop; mask = m; one_shot = os;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    mask = 4'($urandom_range(0, 15));
    one_shot = 1'($urandom_range(0, 1));
  endtask

  task automatic pulse_stop();
    @(posedge clk); #1;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
  endtask

  // cap[k][i] holds instance k outputs in cycle i after the call point.
  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) cap[k][i] = dut_out(k);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int cnt;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) check5("reset_idle", dut_out(k), 5'b00000);

    // Full one-shot pass, DIV=1 DWELL=2 BLANK=1 on u0.
    pulse_start(4'b1111, 1'b1, 1'b0);
    capture(16);
    check5("os_t0",  cap[0][0],  5'b01100);
    check5("os_t1",  cap[0][1],  5'b01100);
    check5("os_t2",  cap[0][2],  5'b01000);
    check5("os_t3",  cap[0][3],  5'b01101);
    check5("os_t5",  cap[0][5],  5'b01001);
    check5("os_t6",  cap[0][6],  5'b01110);
    check5("os_t9",  cap[0][9],  5'b01111);
    check5("os_t11", cap[0][11], 5'b01011);
    check5("os_done", cap[0][12], 5'b10000);
    check5("os_after", cap[0][13], 5'b00000);
    cnt = 0;
    for (int i = 0; i < 12; i++) cnt += int'(cap[0][i][2]);
    check_int("os_en_cycles", cnt, 8);

    pulse_stop();
    @(negedge clk);
    check5("stop_u1_first", dut_out(1), 5'b00000);

    // Continuous alternating 1,3 with DIV=4 DWELL=3 on u1.
    pulse_start(4'b1010, 1'b0, 1'b0);
    capture(40);
    check5("cont_t0",  cap[1][0],  5'b01101);
    check5("cont_t11", cap[1][11], 5'b01101);
    check5("cont_t12", cap[1][12], 5'b01001);
    check5("cont_t15", cap[1][15], 5'b01001);
    check5("cont_t16", cap[1][16], 5'b01111);
    check5("cont_t27", cap[1][27], 5'b01111);
    check5("cont_t28", cap[1][28], 5'b01011);
    check5("cont_t32", cap[1][32], 5'b01101);
    cnt = 0;
    for (int i = 0; i < 40; i++) cnt += int'(cap[1][i][4]);
    check_int("cont_no_done", cnt, 0);
    pulse_stop();
    @(negedge clk);
    check5("cont_stop", dut_out(1), 5'b00000);

    // Boundaries: empty mask, start with stop, start while busy.
    pulse_start(4'b0000, 1'b1, 1'b0);
    capture(4);
    check5("mask0_t0", cap[0][0], 5'b00000);
    check5("mask0_t3", cap[1][3], 5'b00000);
    pulse_start(4'b1111, 1'b1, 1'b1);
    capture(3);
    check5("start_stop", cap[0][0], 5'b00000);
    pulse_start(4'b1111, 1'b1, 1'b0);
    pulse_start(4'b0001, 1'b0, 1'b0);
    capture(12);
    check5("busy_start_t3", cap[0][1], 5'b01101);
    check5("busy_start_done", cap[0][10], 5'b10000);
    pulse_stop();

    // Single channel: one-shot then continuous without blanking.
    pulse_start(4'b0100, 1'b1, 1'b0);
    capture(6);
    check5("single_t1", cap[0][1], 5'b01110);
    check5("single_t2", cap[0][2], 5'b01010);
    check5("single_done", cap[0][3], 5'b10000);
    check5("single_u2_t3", cap[2][3], 5'b01110);
    check5("single_u2_done", cap[2][4], 5'b10000);
    pulse_stop();
    pulse_start(4'b0100, 1'b0, 1'b0);
    capture(24);
    cnt = 0;
    for (int i = 0; i < 24; i++) cnt += int'(cap[2][i] == 5'b01110);
    check_int("noblank_en_steady", cnt, 24);
    pulse_stop();

    // Asynchronous reset in the middle of a scan.
    pulse_start(4'b1011, 1'b0, 1'b0);
    repeat (7) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) check5("async_reset", dut_out(k), 5'b00000);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    capture(10);
    cnt = 0;
    for (int i = 0; i < 10; i++) cnt += int'(cap[0][i] != 5'b00000) + int'(cap[1][i] != 5'b00000);
    check_int("post_reset_idle", cnt, 0);

    // Randomized traffic against the model.
    repeat (1500) begin
      @(posedge clk); #1;
      start    = ($urandom_range(0, 11) == 0);
      stop     = ($urandom_range(0, 70) == 0);
      mask     = 4'($urandom_range(0, 15));
      one_shot = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    repeat (80) @(posedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
